alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Buffers completed ALU results between the combinational `yAlu` and the writeback stage. Each entry holds the 32-bit result `z`, the `ex` (zero) flag, the 3-bit opcode and a 5-bit destination tag, accepted with a valid/ready handshake. The FIFO decouples the single-cycle ALU from writeback stalls. Occupancy and a sticky overflow flag are exported for debug.

## Interface
- `DEPTH`, 4, number of entries; power of two, at least 2
- `TAG_W`, 5, destination-register tag width
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous discard of all entries
- `in_valid`  in  1  upstream ALU result valid
- `in_ready`  out  1  FIFO can accept this cycle
- `in_z`  in  32  ALU result
- `in_ex`  in  1  ALU zero flag
- `in_op`  in  3  opcode that produced result
- `in_tag`  in  TAG_W  destination tag
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  writeback consumes head
- `out_z`, `out_ex`, `out_op`, `out_tag`  out  32/1/3/TAG_W  head entry fields
- `count`  out  log2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: push attempted while full

## Operation
- Storage: circular buffer, read pointer and write pointer of log2(DEPTH) bits, wrap modulo DEPTH; separate occupancy counter of log2(DEPTH)+1 bits.
- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`, derived from registered count only. Push is refused when full even if a pop occurs the same cycle.
- `out_valid = (count != 0)`. `out_*` fields come from the head entry when valid and are forced to 0 when `out_valid` = 0.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, and both pointers advance
- `overflow` is set when `in_valid && !in_ready`. It is cleared only by `rst`; `flush` does not clear it.
- Flush has priority over push and pop in the same cycle: pointers and count go to 0, and the incoming data is dropped. Storage contents are not cleared.
- Fields are stored and returned bit-exact. No arithmetic is performed on the data.

## Timing
- Reset, next edge with `rst` = 1: pointers 0, count 0, `in_ready` 1, `out_valid` 0, all `out_*` 0, `overflow` 0. `rst` overrides `flush` and any handshake.
- Latency: a push at edge N makes the entry visible on `out_*` after edge N, i.e. one cycle.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Full: `in_ready` falls the cycle after the DEPTH-th push and rises the cycle after the first pop.
- Empty: `out_valid` falls the cycle after the last pop.
- Reset or flush mid-stream: all entries are lost, and the following cycle looks identical to post-reset, except that `overflow` persists after a flush.

## Configuration
- `ALU_RESULT_FIFO_BYPASS_EN` defined:
  - When count = 0 and not flushing, `out_valid = in_valid` and `out_*` = `in_*` combinationally.
  - If `out_ready` = 1 that cycle, the result is consumed with zero latency and is not written; count stays 0.
  - If `out_ready` = 0, the entry is written normally.
  - `in_ready` is unchanged.
- Undefined: strict one-cycle latency as specified above; no combinational path from input to output.

## Test plan
- Reset then 3 pushes (`z` = 0x0000000A, 0xFFFFFFFF, 0x00000001; tags 1, 2, 3) with `out_ready` = 0 → count 3, `out_z` = 0x0000000A, `out_tag` = 1; then `out_ready` = 1 → results pop in order over 3 cycles, `out_valid` low on cycle 4.
- Fill 4 entries, then hold `in_valid` = 1 with `out_ready` = 0 → `in_ready` 0, count stays 4, `overflow` 1 and it stays 1 after one pop.
- Continuous push+pop for 10 cycles with random `a`/`b` and op 010 (`z` = `a`+`b`) → count constant at 1, outputs match inputs delayed one cycle, pointers wrap past 3 → 0 without loss.
- Flush asserted with count 3 and `in_valid` = 1 → next cycle count 0, `out_valid` 0, `out_z` 0, `in_ready` 1.
- With `ALU_RESULT_FIFO_BYPASS_EN`, empty FIFO, push `z` = 0x12345678 with `out_ready` = 1 → same-cycle `out_valid` 1, `out_z` = 0x12345678, count stays 0. Without the macro → output appears the next cycle and count goes 1 then 0.
- `rst` asserted with count 2 and simultaneous push/pop → next cycle all outputs at reset values, `overflow` 0.

Source files
------------

// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if
//   Handshake bundle between the ALU (producer), the result FIFO and the
//   writeback stage (consumer).
//
//   Both sides use the same valid/ready contract:
//     * A transfer happens on a rising clk edge where valid && ready.
//     * A producer holding valid=1 keeps its payload stable until the transfer.
//     * ready may be asserted without valid.
//     * ready never depends combinationally on valid of the same side.
//
//   Modports:
//     master : ALU/writeback side. Drives in_* and out_ready, observes in_ready and out_*.
//     slave  : the FIFO. Observes in_* and out_ready, drives in_ready and out_*.
//
//   Parameters:
//     TAG_W : destination-register tag width

interface alu_result_fifo_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_z;
  logic             in_ex;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_z;
  logic             out_ex;
  logic [2:0]       out_op;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_z, in_ex, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_z, out_ex, out_op, out_tag
  );

  modport slave (
    input  in_valid, in_z, in_ex, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_z, out_ex, out_op, out_tag
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Circular-buffer FIFO holding completed ALU results (z, zero flag, opcode,
//   destination tag) between the ALU and the writeback stage.
//
//   Ports:
//     clk      : single clock, rising edge
//     rst      : synchronous, active-high reset (overrides flush and handshakes)
//     flush    : synchronous discard of all entries (overflow is kept)
//     bus      : alu_result_fifo_if.slave, in_* push side and out_* pop side
//     count    : current occupancy, 0..DEPTH
//     overflow : sticky, set when a push is offered while full; cleared by rst only
//
//   Parameters:
//     DEPTH : number of entries, power of two, >= 2
//     TAG_W : destination tag width (must match the interface)
//
//   Optional feature:
//     ALU_RESULT_FIFO_BYPASS_EN : when defined, an empty FIFO forwards in_* to
//     out_* combinationally; a result consumed that same cycle is never stored.
//     When undefined, results always take one cycle and out_* are purely
//     registered state.

module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  alu_result_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [31:0]      z;
    logic             ex;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_next;

  entry_t in_entry;
  entry_t head;
  entry_t out_entry;
  logic   head_valid;
  logic   push;
  logic   wr_en;
  logic   rd_en;

  assign in_entry = '{z: bus.in_z, ex: bus.in_ex, op: bus.in_op, tag: bus.in_tag};
  assign head     = mem[rd_ptr];

  // in_ready looks at the registered count only, so a pop in the same cycle
  // does not open a slot for a push.
  assign bus.in_ready = (count != FULL_CNT);
  assign head_valid   = (count != '0);
  assign push         = bus.in_valid && bus.in_ready;
  assign rd_en        = head_valid && bus.out_ready;

`ifdef ALU_RESULT_FIFO_BYPASS_EN
  logic bypass;

  // Forwarding only while empty and not flushing; a forwarded result that is
  // taken immediately skips storage, otherwise it is written as a normal push.
  assign bypass        = !head_valid && !flush && bus.in_valid;
  assign bus.out_valid = head_valid || bypass;
  assign out_entry     = head_valid ? head : (bypass ? in_entry : '0);
  assign wr_en         = push && !(bypass && bus.out_ready);
`else
  assign bus.out_valid = head_valid;
  assign out_entry     = head_valid ? head : '0;
  assign wr_en         = push;
`endif

  assign bus.out_z   = out_entry.z;
  assign bus.out_ex  = out_entry.ex;
  assign bus.out_op  = out_entry.op;
  assign bus.out_tag = out_entry.tag;

  always_comb begin
    count_next = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Storage is never cleared; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !flush && !rst) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.in_valid && !bus.in_ready) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
//   Self-checking bench for alu_result_fifo (DEPTH=4, TAG_W=5).
//   Directed table of post-edge expectations, hand-written corner sequences,
//   then random traffic checked every cycle against a queue-based model.

module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
`ifdef ALU_RESULT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       overflow;

  alu_result_fifo_if #(.TAG_W(TAG_W)) bus ();

  alu_result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .count    (count),
    .overflow (overflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  // Entry packing: {z, ex, op, tag}
  logic [40:0] exp_q[$];
  logic        exp_ovf;
  int          n_vec;
  int          n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs implied by the model state and the current inputs (before the edge).
  task automatic model_check();
    int          sz;
    logic [40:0] h;
    logic        ov;
    sz = exp_q.size();
    ov = (sz != 0);
    h  = '0;
    if (sz != 0) h = exp_q[0];
    else if (BYP && !flush && bus.in_valid) begin
      ov = 1'b1;
      h  = {bus.in_z, bus.in_ex, bus.in_op, bus.in_tag};
    end
    chk("m_count",     64'(count),         64'(sz));
    chk("m_in_ready",  64'(bus.in_ready),  64'(sz != DEPTH));
    chk("m_overflow",  64'(overflow),      64'(exp_ovf));
    chk("m_out_valid", 64'(bus.out_valid), 64'(ov));
    chk("m_out_entry", 64'({bus.out_z, bus.out_ex, bus.out_op, bus.out_tag}), 64'(h));
  endtask

  // Advance the model by one edge using the inputs seen at that edge.
  task automatic model_update();
    int   sz;
    logic rdy;
    logic take_now;
    sz  = exp_q.size();
    rdy = (sz != DEPTH);
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (bus.in_valid && !rdy) exp_ovf = 1'b1;
      if (flush) exp_q.delete();
      else begin
        take_now = BYP && (sz == 0) && bus.out_ready;
        if (sz != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (bus.in_valid && rdy && !take_now)
          exp_q.push_back({bus.in_z, bus.in_ex, bus.in_op, bus.in_tag});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] z,
                       input logic [TAG_W-1:0] tag, input logic ordy);
    rst           = r;
    flush         = f;
    bus.in_valid  = iv;
    bus.in_z      = z;
    bus.in_ex     = (z == 32'h0);
    bus.in_op     = tag[2:0];
    bus.in_tag    = tag;
    bus.out_ready = ordy;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             r, f, iv;
    logic [31:0]      z;
    logic [TAG_W-1:0] tag;
    logic             ordy;
    logic [2:0]       e_cnt;
    logic             e_ov;
    logic [31:0]      e_z;
    logic [TAG_W-1:0] e_tag;
    logic             e_rdy;
    logic             e_ovf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, f, iv, input logic [31:0] z, input logic [TAG_W-1:0] tag,
                     input logic ordy, input logic [2:0] e_cnt, input logic e_ov,
                     input logic [31:0] e_z, input logic [TAG_W-1:0] e_tag,
                     input logic e_rdy, input logic e_ovf);
    vec_t v;
    v = '{r, f, iv, z, tag, ordy, e_cnt, e_ov, e_z, e_tag, e_rdy, e_ovf};
    vq.push_back(v);
  endtask

  logic [31:0] a, b, zsum;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    exp_ovf = 1'b0;
    idle();
    rst = 1'b1;

    //  r  f  iv z             tag ordy  cnt ov z             tag rdy ovf
    add(1, 0, 0, 32'h0,        0,  0,    0,  0, 32'h0,        0,  1,  0); // reset
    add(0, 0, 1, 32'h0000000A, 1,  0,    1,  1, 32'h0000000A, 1,  1,  0);
    add(0, 0, 1, 32'hFFFFFFFF, 2,  0,    2,  1, 32'h0000000A, 1,  1,  0);
    add(0, 0, 1, 32'h00000001, 3,  0,    3,  1, 32'h0000000A, 1,  1,  0);
    add(0, 0, 0, 32'h0,        0,  1,    2,  1, 32'hFFFFFFFF, 2,  1,  0); // drain in order
    add(0, 0, 0, 32'h0,        0,  1,    1,  1, 32'h00000001, 3,  1,  0);
    add(0, 0, 0, 32'h0,        0,  1,    0,  0, 32'h0,        0,  1,  0); // empty
    add(0, 0, 1, 32'h11,       4,  0,    1,  1, 32'h11,       4,  1,  0); // fill
    add(0, 0, 1, 32'h22,       5,  0,    2,  1, 32'h11,       4,  1,  0);
    add(0, 0, 1, 32'h33,       6,  0,    3,  1, 32'h11,       4,  1,  0);
    add(0, 0, 1, 32'h44,       7,  0,    4,  1, 32'h11,       4,  0,  0); // full
    add(0, 0, 1, 32'h55,       8,  0,    4,  1, 32'h11,       4,  0,  1); // refused -> overflow
    add(0, 0, 1, 32'h55,       8,  1,    3,  1, 32'h22,       5,  1,  1); // pop, push still refused
    add(0, 0, 1, 32'h66,       9,  0,    4,  1, 32'h22,       5,  0,  1);
    add(0, 0, 0, 32'h0,        0,  1,    3,  1, 32'h33,       6,  1,  1);
    add(0, 1, 1, 32'h77,       9,  1,    0,  0, 32'h0,        0,  1,  1); // flush wins, ovf kept
    add(0, 0, 1, 32'h88,       10, 0,    1,  1, 32'h88,       10, 1,  1);
    add(0, 0, 1, 32'h99,       11, 0,    2,  1, 32'h88,       10, 1,  1);
    add(1, 0, 1, 32'hAA,       12, 1,    0,  0, 32'h0,        0,  1,  0); // reset mid-stream

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].f, vq[i].iv, vq[i].z, vq[i].tag, vq[i].ordy);
      cycle();
      idle();
      #1;
      chk("t_count",     64'(count),         64'(vq[i].e_cnt));
      chk("t_out_valid", 64'(bus.out_valid), 64'(vq[i].e_ov));
      chk("t_out_z",     64'(bus.out_z),     64'(vq[i].e_z));
      chk("t_out_tag",   64'(bus.out_tag),   64'(vq[i].e_tag));
      chk("t_in_ready",  64'(bus.in_ready),  64'(vq[i].e_rdy));
      chk("t_overflow",  64'(overflow),      64'(vq[i].e_ovf));
    end

    // ---- latency / bypass on an empty FIFO ----
    drive(0, 0, 1, 32'h12345678, 5'd7, 1'b1);
    @(negedge clk);
    chk("byp_out_valid", 64'(bus.out_valid), 64'(BYP));
    chk("byp_out_z",     64'(bus.out_z),     BYP ? 64'h12345678 : 64'h0);
    model_check();
    @(posedge clk);
    model_update();
    #1;
    idle();
    bus.out_ready = 1'b1;
    #1;
    chk("byp_count_1", 64'(count), BYP ? 64'd0 : 64'd1);
    chk("byp_next_z",  64'(bus.out_z), BYP ? 64'h0 : 64'h12345678);
    cycle();
    chk("byp_count_2", 64'(count), 64'd0);

    // ---- continuous push+pop, op 010, z = a + b; pointers wrap ----
    drive(0, 0, 1, 32'h5, 5'd2, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      a    = $urandom;
      b    = $urandom;
      zsum = a + b;
      drive(0, 0, 1, zsum, 5'd2, 1'b1);
      cycle();
      idle();
      #1;
      chk("pp_count", 64'(count),     64'd1);
      chk("pp_out_z", 64'(bus.out_z), 64'(zsum));
      chk("pp_op",    64'(bus.out_op), 64'd2);
    end

    // ---- random traffic ----
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
            TAG_W'($urandom), ($urandom_range(0, 1) == 1));
      cycle();
    end
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    chk("final_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
